// File: rtl/mem_wb_queue_if.sv
// mem_wb_queue_if: execute-side, memory-side, writeback and forwarding
// signals of the memory/writeback stage. The slave modport is the stage
// itself; the master modport is whatever surrounds it.
interface mem_wb_queue_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int DEPTH  = 4
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              ex_valid;
    logic              ex_ready;
    logic              ex_is_load;
    logic              ex_is_store;
    logic              ex_wr_en;
    logic [REG_W-1:0]  ex_rd;
    logic [DATA_W-1:0] ex_result;
    logic [DATA_W-1:0] ex_store_data;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [DATA_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_rdata;

    logic              wb_en;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;

    logic [OCC_W-1:0]  occupancy;
    logic              rsp_err;

    logic [REG_W-1:0]  fwd_rs;
    logic              fwd_hit;
    logic              fwd_stall;
    logic [DATA_W-1:0] fwd_data;

    modport master (
        output ex_valid, ex_is_load, ex_is_store, ex_wr_en, ex_rd, ex_result,
               ex_store_data, mem_req_ready, mem_rsp_valid, mem_rsp_rdata, fwd_rs,
        input  ex_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
               wb_en, wb_rd, wb_data, occupancy, rsp_err, fwd_hit, fwd_stall, fwd_data
    );

    modport slave (
        input  ex_valid, ex_is_load, ex_is_store, ex_wr_en, ex_rd, ex_result,
               ex_store_data, mem_req_ready, mem_rsp_valid, mem_rsp_rdata, fwd_rs,
        output ex_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
               wb_en, wb_rd, wb_data, occupancy, rsp_err, fwd_hit, fwd_stall, fwd_data
    );
endinterface

// File: rtl/mem_wb_queue.sv
// mem_wb_queue: memory/writeback stage. Ops from execute are pushed in
// program order into a DEPTH-entry circular completion queue; loads and
// stores are issued to data memory in the same cycle they are pushed.
// Load data fills the oldest outstanding load entry, and the head entry
// retires to the register-file write port once it is done.
// Optional feature macro: WB_FORWARD_EN builds the forwarding query
// (fwd_hit/fwd_stall/fwd_data); without it those outputs are tied to 0.
// DEPTH must be a power of two and at least 2.
module mem_wb_queue #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int DEPTH  = 4
) (
    input logic           clk,
    input logic           rst,
    mem_wb_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    // Queue storage, one bit/field per entry.
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [DEPTH-1:0]  wr_en_q, wr_en_d;
    logic [REG_W-1:0]  rd_q   [DEPTH];
    logic [REG_W-1:0]  rd_d   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    // Pointers carry a wrap bit above the index bits.
    logic [PTR_W:0]    head_q, head_d;
    logic [PTR_W:0]    tail_q, tail_d;

    // Registered writeback port and sticky error.
    logic              wb_en_q, wb_en_d;
    logic [REG_W-1:0]  wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic [PTR_W-1:0]  head_idx;
    logic [PTR_W-1:0]  tail_idx;
    logic [PTR_W-1:0]  scan_idx;
    logic [PTR_W-1:0]  ld_idx;
    logic              ld_found;
    logic              is_mem;
    logic              is_load;
    logic              full;
    logic              ex_ready;
    logic              push;
    logic              pop;

    assign head_idx = head_q[PTR_W-1:0];
    assign tail_idx = tail_q[PTR_W-1:0];
    assign full     = (head_q[PTR_W] != tail_q[PTR_W]) && (head_idx == tail_idx);

    // An op flagged as both load and store is illegal; it is handled as a
    // store so that it never leaves a not-done entry waiting for data.
    assign is_mem   = bus.ex_is_load || bus.ex_is_store;
    assign is_load  = bus.ex_is_load && !bus.ex_is_store;

    // A retire in the same cycle does not free a slot for the incoming op,
    // keeping ex_ready independent of queue contents beyond the full flag.
    assign ex_ready = !full && (!is_mem || bus.mem_req_ready);
    assign push     = bus.ex_valid && ex_ready;
    assign pop      = valid_q[head_idx] && done_q[head_idx];

    // Find the oldest not-done entry; since loads complete in order this
    // is the load that the next memory response belongs to.
    always_comb begin
        ld_found = 1'b0;
        ld_idx   = '0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_idx + PTR_W'(i);
            if (!ld_found && valid_q[scan_idx] && !done_q[scan_idx]) begin
                ld_found = 1'b1;
                ld_idx   = scan_idx;
            end
        end
    end

    // Next-state: retire the head, absorb a load response, push the new op.
    always_comb begin
        valid_d   = valid_q;
        done_d    = done_q;
        wr_en_d   = wr_en_q;
        rd_d      = rd_q;
        data_d    = data_q;
        head_d    = head_q;
        tail_d    = tail_q;
        wb_en_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        rsp_err_d = rsp_err_q;

        if (pop) begin
            valid_d[head_idx] = 1'b0;
            done_d[head_idx]  = 1'b0;
            head_d            = head_q + 1'b1;
            wb_en_d           = wr_en_q[head_idx] && (rd_q[head_idx] != '0);
            wb_rd_d           = rd_q[head_idx];
            wb_data_d         = data_q[head_idx];
        end

        if (bus.mem_rsp_valid) begin
            if (ld_found) begin
                data_d[ld_idx] = bus.mem_rsp_rdata;
                done_d[ld_idx] = 1'b1;
            end else begin
                rsp_err_d = 1'b1;
            end
        end

        if (push) begin
            valid_d[tail_idx] = 1'b1;
            done_d[tail_idx]  = !is_load;
            wr_en_d[tail_idx] = bus.ex_wr_en && !bus.ex_is_store;
            rd_d[tail_idx]    = bus.ex_rd;
            data_d[tail_idx]  = bus.ex_result;
            tail_d            = tail_q + 1'b1;
        end
    end

    // State register with synchronous reset; reset drops every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            done_q    <= '0;
            wr_en_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            wb_en_q   <= wb_en_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign bus.ex_ready      = ex_ready;
    assign bus.mem_req_valid = bus.ex_valid && is_mem && !full;
    assign bus.mem_req_we    = bus.ex_is_store;
    assign bus.mem_req_addr  = bus.ex_result;
    assign bus.mem_req_wdata = bus.ex_store_data;
    assign bus.wb_en         = wb_en_q;
    assign bus.wb_rd         = wb_rd_q;
    assign bus.wb_data       = wb_data_q;
    assign bus.occupancy     = OCC_W'(tail_q - head_q);
    assign bus.rsp_err       = rsp_err_q;

`ifdef WB_FORWARD_EN
    logic [PTR_W-1:0]  fwd_idx;
    logic              fwd_hit;
    logic              fwd_stall;
    logic [DATA_W-1:0] fwd_data;

    // Walk the queue oldest to youngest so the youngest matching writer wins.
    always_comb begin
        fwd_hit   = 1'b0;
        fwd_stall = 1'b0;
        fwd_data  = '0;
        fwd_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_idx + PTR_W'(i);
            if (valid_q[fwd_idx] && wr_en_q[fwd_idx] &&
                (rd_q[fwd_idx] == bus.fwd_rs) && (rd_q[fwd_idx] != '0)) begin
                fwd_hit   = 1'b1;
                fwd_stall = !done_q[fwd_idx];
                fwd_data  = done_q[fwd_idx] ? data_q[fwd_idx] : '0;
            end
        end
    end

    assign bus.fwd_hit   = fwd_hit;
    assign bus.fwd_stall = fwd_stall;
    assign bus.fwd_data  = fwd_data;
`else
    logic unused_fwd_rs;
    assign unused_fwd_rs = ^bus.fwd_rs;
    assign bus.fwd_hit   = 1'b0;
    assign bus.fwd_stall = 1'b0;
    assign bus.fwd_data  = '0;
`endif
endmodule

// File: tb/tb_mem_wb_queue.sv
// tb_mem_wb_queue: directed vector table, hand-written reset/forwarding
// sequences and randomized traffic against a queue-based reference model.
module tb_mem_wb_queue;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int DEPTH  = 4;
    localparam int NVEC   = 35;
`ifdef WB_FORWARD_EN
    localparam logic FWD_ON = 1'b1;
`else
    localparam logic FWD_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_wb_queue_if #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH)) bus ();

    mem_wb_queue #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic              valid;
        logic              is_load;
        logic              is_store;
        logic              wr_en;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] sdata;
        logic              req_ready;
        logic              rsp_valid;
        logic [DATA_W-1:0] rdata;
        logic [REG_W-1:0]  fwd_rs;
    } stim_t;

    typedef struct packed {
        stim_t             s;
        logic              exp_ready;
        logic              exp_req_valid;
        logic              exp_wb_en;
        logic [REG_W-1:0]  exp_wb_rd;
        logic [DATA_W-1:0] exp_wb_data;
        logic [3:0]        exp_occ;
    } vec_t;

    typedef struct {
        logic [REG_W-1:0]  rd;
        logic              wr_en;
        logic              done;
        logic [DATA_W-1:0] data;
    } ent_t;

    int checks   = 0;
    int failures = 0;

    // Reference model: the queue contents in program order plus the
    // registered writeback values and sticky error.
    ent_t              mq[$];
    logic              m_wb_en;
    logic [REG_W-1:0]  m_wb_rd;
    logic [DATA_W-1:0] m_wb_data;
    logic              m_rsp_err;

    logic              obs_ready, obs_req_valid, obs_hit, obs_stall;
    logic [DATA_W-1:0] obs_data;

    vec_t vecs [NVEC];

    function automatic stim_t mk(logic v, logic ld, logic st, logic we, logic [REG_W-1:0] rd,
                                 logic [DATA_W-1:0] res, logic [DATA_W-1:0] sd, logic rr,
                                 logic rv, logic [DATA_W-1:0] rdat, logic [REG_W-1:0] frs);
        stim_t s;
        s.valid = v; s.is_load = ld; s.is_store = st; s.wr_en = we; s.rd = rd;
        s.result = res; s.sdata = sd; s.req_ready = rr; s.rsp_valid = rv;
        s.rdata = rdat; s.fwd_rs = frs;
        return s;
    endfunction

    function automatic vec_t mv(stim_t s, logic er, logic erv, logic ewb,
                                logic [REG_W-1:0] wrd, logic [DATA_W-1:0] wdat, logic [3:0] occ);
        vec_t v;
        v.s = s; v.exp_ready = er; v.exp_req_valid = erv; v.exp_wb_en = ewb;
        v.exp_wb_rd = wrd; v.exp_wb_data = wdat; v.exp_occ = occ;
        return v;
    endfunction

    function automatic stim_t idle(logic rv, logic [DATA_W-1:0] rdat, logic [REG_W-1:0] frs);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, rv, rdat, frs);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic driveInputs(input stim_t s);
        bus.ex_valid      = s.valid;
        bus.ex_is_load    = s.is_load;
        bus.ex_is_store   = s.is_store;
        bus.ex_wr_en      = s.wr_en;
        bus.ex_rd         = s.rd;
        bus.ex_result     = s.result;
        bus.ex_store_data = s.sdata;
        bus.mem_req_ready = s.req_ready;
        bus.mem_rsp_valid = s.rsp_valid;
        bus.mem_rsp_rdata = s.rdata;
        bus.fwd_rs        = s.fwd_rs;
    endtask

    // One clock cycle: drive, check combinational outputs, clock the model
    // and the DUT, then check registered outputs.
    task automatic applyStimulus(input stim_t s);
        logic              e_ready, e_req_valid, e_hit, e_stall, is_mem, do_pop, found;
        logic [DATA_W-1:0] e_data;
        ent_t              e;
        @(negedge clk);
        driveInputs(s);
        #1;
        is_mem      = s.is_load || s.is_store;
        e_ready     = (mq.size() < DEPTH) && (!is_mem || s.req_ready);
        e_req_valid = s.valid && is_mem && (mq.size() < DEPTH);
        e_hit = 1'b0; e_stall = 1'b0; e_data = '0;
        if (FWD_ON) begin
            foreach (mq[i]) begin
                if (mq[i].wr_en && mq[i].rd == s.fwd_rs && mq[i].rd != 0) begin
                    e_hit   = 1'b1;
                    e_stall = !mq[i].done;
                    e_data  = mq[i].data;
                end
            end
        end
        obs_ready = bus.ex_ready; obs_req_valid = bus.mem_req_valid;
        obs_hit = bus.fwd_hit; obs_stall = bus.fwd_stall; obs_data = bus.fwd_data;
        checkOutput("ex_ready", bus.ex_ready, e_ready);
        checkOutput("mem_req_valid", bus.mem_req_valid, e_req_valid);
        if (e_req_valid) begin
            checkOutput("mem_req_we", bus.mem_req_we, s.is_store);
            checkOutput("mem_req_addr", bus.mem_req_addr, s.result);
            if (s.is_store) checkOutput("mem_req_wdata", bus.mem_req_wdata, s.sdata);
        end
        checkOutput("fwd_hit", bus.fwd_hit, e_hit);
        checkOutput("fwd_stall", bus.fwd_stall, e_stall);
        if (!FWD_ON || (e_hit && !e_stall)) checkOutput("fwd_data", bus.fwd_data, e_data);

        @(posedge clk);
        do_pop  = (mq.size() > 0) && mq[0].done;
        m_wb_en = 1'b0;
        if (do_pop) begin
            m_wb_en   = mq[0].wr_en && (mq[0].rd != 0);
            m_wb_rd   = mq[0].rd;
            m_wb_data = mq[0].data;
        end
        if (s.rsp_valid) begin
            found = 1'b0;
            foreach (mq[i]) begin
                if (!found && !mq[i].done) begin
                    e = mq[i]; e.done = 1'b1; e.data = s.rdata; mq[i] = e;
                    found = 1'b1;
                end
            end
            if (!found) m_rsp_err = 1'b1;
        end
        if (do_pop) void'(mq.pop_front());
        if (s.valid && e_ready) begin
            e.rd = s.rd; e.wr_en = s.wr_en && !s.is_store;
            e.done = !s.is_load; e.data = s.result;
            mq.push_back(e);
        end
        #1;
        checkOutput("wb_en", bus.wb_en, m_wb_en);
        if (m_wb_en) begin
            checkOutput("wb_rd", bus.wb_rd, m_wb_rd);
            checkOutput("wb_data", bus.wb_data, m_wb_data);
        end
        checkOutput("occupancy", bus.occupancy, mq.size());
        checkOutput("rsp_err", bus.rsp_err, m_rsp_err);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        driveInputs(idle(1'b0, '0, '0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        m_wb_en = 1'b0; m_wb_rd = '0; m_wb_data = '0; m_rsp_err = 1'b0;
        #1;
    endtask

    initial begin
        stim_t s;
        int    pend;
        int    op;

        // Directed vector table: ALU stream, rd=0, store, ordering, full, backpressure.
        for (int k = 0; k < 8; k++)
            vecs[k] = mv(mk(1, 0, 0, 1, REG_W'(k + 1), DATA_W'(32'h10 + k), '0, 1, 0, '0, '0),
                         1, 0, (k > 0), REG_W'(k), DATA_W'(32'h10 + k - 1), 4'd1);
        vecs[8]  = mv(mk(1, 0, 0, 1, 5'd0, 32'h99, '0, 1, 0, '0, '0), 1, 0, 1, 5'd8, 32'h17, 4'd1);
        vecs[9]  = mv(idle(0, '0, '0), 1, 0, 0, '0, '0, 4'd0);
        vecs[10] = mv(mk(1, 0, 1, 1, 5'd7, 32'h40, 32'hDEAD, 1, 0, '0, '0), 1, 1, 0, '0, '0, 4'd1);
        vecs[11] = mv(idle(0, '0, '0), 1, 0, 0, '0, '0, 4'd0);
        vecs[12] = mv(mk(1, 1, 0, 1, 5'd3, 32'h100, '0, 1, 0, '0, '0), 1, 1, 0, '0, '0, 4'd1);
        vecs[13] = mv(mk(1, 0, 0, 1, 5'd4, 32'hAA, '0, 1, 0, '0, '0), 1, 0, 0, '0, '0, 4'd2);
        for (int k = 14; k < 17; k++) vecs[k] = mv(idle(0, '0, '0), 1, 0, 0, '0, '0, 4'd2);
        vecs[17] = mv(idle(1, 32'h1234, '0), 1, 0, 0, '0, '0, 4'd2);
        vecs[18] = mv(idle(0, '0, '0), 1, 0, 1, 5'd3, 32'h1234, 4'd1);
        vecs[19] = mv(idle(0, '0, '0), 1, 0, 1, 5'd4, 32'hAA, 4'd0);
        vecs[20] = mv(idle(0, '0, '0), 1, 0, 0, '0, '0, 4'd0);
        for (int j = 0; j < 4; j++)
            vecs[21 + j] = mv(mk(1, 1, 0, 1, REG_W'(9 + j), DATA_W'(32'h200 + 4 * j), '0, 1, 0, '0, '0),
                              1, 1, 0, '0, '0, 4'(j + 1));
        vecs[25] = mv(mk(1, 1, 0, 1, 5'd13, 32'h210, '0, 1, 0, '0, '0), 0, 0, 0, '0, '0, 4'd4);
        vecs[26] = mv(mk(1, 0, 0, 1, 5'd14, 32'h66, '0, 1, 0, '0, '0), 0, 0, 0, '0, '0, 4'd4);
        vecs[27] = mv(idle(1, 32'h300, '0), 0, 0, 0, '0, '0, 4'd4);
        vecs[28] = mv(idle(1, 32'h301, '0), 0, 0, 1, 5'd9, 32'h300, 4'd3);
        vecs[29] = mv(idle(1, 32'h302, '0), 1, 0, 1, 5'd10, 32'h301, 4'd2);
        vecs[30] = mv(idle(1, 32'h303, '0), 1, 0, 1, 5'd11, 32'h302, 4'd1);
        vecs[31] = mv(idle(0, '0, '0), 1, 0, 1, 5'd12, 32'h303, 4'd0);
        vecs[32] = mv(mk(1, 1, 0, 1, 5'd16, 32'h500, '0, 0, 0, '0, '0), 0, 1, 0, '0, '0, 4'd0);
        vecs[33] = mv(mk(1, 0, 0, 1, 5'd15, 32'h55, '0, 0, 0, '0, '0), 1, 0, 0, '0, '0, 4'd1);
        vecs[34] = mv(idle(0, '0, '0), 1, 0, 1, 5'd15, 32'h55, 4'd0);

        driveInputs(idle(1'b0, '0, '0));
        doReset();
        checkOutput("reset wb_en", bus.wb_en, 1'b0);
        checkOutput("reset wb_rd", bus.wb_rd, '0);
        checkOutput("reset wb_data", bus.wb_data, '0);
        checkOutput("reset occupancy", bus.occupancy, '0);
        checkOutput("reset rsp_err", bus.rsp_err, 1'b0);
        checkOutput("reset ex_ready", bus.ex_ready, 1'b1);
        checkOutput("reset mem_req_valid", bus.mem_req_valid, 1'b0);
        checkOutput("reset fwd_hit", bus.fwd_hit, 1'b0);
        checkOutput("reset fwd_data", bus.fwd_data, '0);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].s);
            checkOutput($sformatf("vec%0d ex_ready", i), obs_ready, vecs[i].exp_ready);
            checkOutput($sformatf("vec%0d mem_req_valid", i), obs_req_valid, vecs[i].exp_req_valid);
            checkOutput($sformatf("vec%0d wb_en", i), bus.wb_en, vecs[i].exp_wb_en);
            if (vecs[i].exp_wb_en) begin
                checkOutput($sformatf("vec%0d wb_rd", i), bus.wb_rd, vecs[i].exp_wb_rd);
                checkOutput($sformatf("vec%0d wb_data", i), bus.wb_data, vecs[i].exp_wb_data);
            end
            checkOutput($sformatf("vec%0d occupancy", i), bus.occupancy, vecs[i].exp_occ);
        end

        // Reset with three loads outstanding, then a stray response.
        for (int k = 1; k <= 3; k++)
            applyStimulus(mk(1, 1, 0, 1, REG_W'(k), DATA_W'(32'h600 + k), '0, 1, 0, '0, '0));
        checkOutput("pre-reset occupancy", bus.occupancy, 3);
        doReset();
        checkOutput("mid reset occupancy", bus.occupancy, '0);
        checkOutput("mid reset wb_en", bus.wb_en, 1'b0);
        checkOutput("mid reset ex_ready", bus.ex_ready, 1'b1);
        applyStimulus(idle(1, 32'hBAD, '0));
        checkOutput("stray rsp_err", bus.rsp_err, 1'b1);
        applyStimulus(idle(0, '0, '0));
        checkOutput("sticky rsp_err", bus.rsp_err, 1'b1);

        // Forwarding from a pending, then completed, load to rd=5.
        doReset();
        applyStimulus(mk(1, 1, 0, 1, 5'd5, 32'h80, '0, 1, 0, '0, 5'd5));
        applyStimulus(idle(0, '0, 5'd5));
        checkOutput("fwd pending hit", obs_hit, FWD_ON);
        checkOutput("fwd pending stall", obs_stall, FWD_ON);
        applyStimulus(idle(1, 32'h77, 5'd5));
        applyStimulus(idle(0, '0, 5'd5));
        checkOutput("fwd done hit", obs_hit, FWD_ON);
        checkOutput("fwd done stall", obs_stall, 1'b0);
        checkOutput("fwd done data", obs_data, FWD_ON ? 32'h77 : 32'h0);
        checkOutput("fwd load wb_data", bus.wb_data, 32'h77);

        // Randomized traffic against the reference model.
        doReset();
        for (int n = 0; n < 600; n++) begin
            pend = 0;
            foreach (mq[i]) if (!mq[i].done) pend++;
            op         = int'($urandom_range(0, 2));
            s.valid    = ($urandom_range(0, 3) != 0);
            s.is_load  = (op == 1);
            s.is_store = (op == 2);
            s.wr_en    = ($urandom_range(0, 3) != 0);
            s.rd       = REG_W'($urandom_range(0, 7));
            s.result   = $urandom;
            s.sdata    = $urandom;
            s.req_ready = ($urandom_range(0, 3) != 0);
            s.rsp_valid = (pend > 0) && ($urandom_range(0, 2) == 0);
            s.rdata    = $urandom;
            s.fwd_rs   = REG_W'($urandom_range(0, 7));
            applyStimulus(s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
